mem_arbiter: RTL and testbench

- Two-requester arbiter and burst sequencer in front of the shared unified `memory` block (clock/address/data_in/access_size/rw/enable/busy/data_out).
- Instruction-fetch port (read-only) and load/store port (read/write) share one memory.
- Block grants one transaction at a time, expands the access_size code into per-word beats with address increment, and returns read data/write-consume strobes to the owner.
- Sits between the fetch/LSU stages and `memory`; round-robin fairness.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the instruction-fetch and load/store ports in front of
// the shared memory. It expands each burst code into per-word beats with an incrementing address.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic [1:0]            if_size,
  output logic                  if_grant,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_rvalid,
  output logic                  if_done,
  input  logic                  d_req,
  input  logic                  d_rw,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [1:0]            d_size,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_wready,
  output logic                  d_grant,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rvalid,
  output logic                  d_done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [1:0]            mem_access_size,
  output logic                  mem_rw,
  output logic                  mem_enable,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  state_t                r_state, w_state_next;
  logic                  r_owner, r_last_grant, r_rw, r_rd_pend;
  logic [1:0]            r_size;
  logic [3:0]            r_beat;
  logic [ADDR_WIDTH-1:0] r_base;

  logic       w_grant_if, w_grant_d, w_accept, w_burst, w_drain;
  logic [3:0] w_last_idx;

  // Round-robin: a tie goes to whichever port was not granted last.
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_d  = 1'b0;
    if (r_state == S_IDLE && !reset) begin
      if (if_req && d_req) begin
        if (r_last_grant == OWN_D) w_grant_if = 1'b1;
        else                       w_grant_d  = 1'b1;
      end else if (if_req) begin
        w_grant_if = 1'b1;
      end else if (d_req) begin
        w_grant_d = 1'b1;
      end
    end
  end

  always_comb begin
    w_last_idx = 4'd0;
    case (r_size)
      2'b00:   w_last_idx = 4'd0;
      2'b01:   w_last_idx = 4'd3;
      2'b10:   w_last_idx = 4'd7;
      default: w_last_idx = 4'd15;
    endcase
  end

  assign w_burst  = (r_state == S_BURST);
  assign w_drain  = (r_state == S_DRAIN);
  assign w_accept = w_burst && !mem_busy;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_if || w_grant_d) w_state_next = S_BURST;
      S_BURST: if (w_accept && r_beat == w_last_idx) w_state_next = S_DRAIN;
      S_DRAIN: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= OWN_D;
      r_owner      <= OWN_IF;
      r_beat       <= 4'd0;
      r_base       <= '0;
      r_size       <= 2'b00;
      r_rw         <= 1'b0;
      r_rd_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rd_pend <= w_accept && r_rw;
      if (w_grant_if || w_grant_d) begin
        r_owner      <= w_grant_d ? OWN_D : OWN_IF;
        r_last_grant <= w_grant_d ? OWN_D : OWN_IF;
        r_base       <= (w_grant_d ? d_addr : if_addr) & WORD_MASK;
        r_size       <= w_grant_d ? d_size : if_size;
        r_rw         <= w_grant_d ? d_rw : 1'b1;
        r_beat       <= 4'd0;
      end else if (w_accept) begin
        r_beat <= r_beat + 4'd1;
      end
    end
  end

  assign if_grant        = w_grant_if;
  assign d_grant         = w_grant_d;
  assign mem_enable      = w_burst;
  assign mem_rw          = w_burst && r_rw;
  assign mem_access_size = w_burst ? r_size : 2'b00;
  // Address wraps naturally at 2^ADDR_WIDTH.
  assign mem_address     = w_burst ? (r_base + {{(ADDR_WIDTH-6){1'b0}}, r_beat, 2'b00}) : '0;
  assign mem_data_in     = (w_burst && !r_rw) ? d_wdata : '0;
  assign d_wready        = w_accept && !r_rw && (r_owner == OWN_D);

  // Read data arrives the cycle after the beat is accepted; the final one lines up with done.
  assign if_rvalid = r_rd_pend && (r_owner == OWN_IF);
  assign d_rvalid  = r_rd_pend && (r_owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_data_out : '0;
  assign d_rdata   = d_rvalid ? mem_data_out : '0;
  assign if_done   = w_drain && (r_owner == OWN_IF);
  assign d_done    = w_drain && (r_owner == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: grant timing, bursts, stalls, fairness,
// abort by reset, and address wrap.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_rw, mem_busy;
  logic [31:0] if_addr, d_addr, d_wdata, mem_data_out;
  logic [1:0]  if_size, d_size;
  logic        if_grant, if_rvalid, if_done, d_wready, d_grant, d_rvalid, d_done;
  logic        mem_rw, mem_enable;
  logic [31:0] if_rdata, d_rdata, mem_address, mem_data_in;
  logic [1:0]  mem_access_size;
  logic [138:0] all_out;

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_size(if_size), .if_grant(if_grant),
    .if_rdata(if_rdata), .if_rvalid(if_rvalid), .if_done(if_done),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
    .d_wready(d_wready), .d_grant(d_grant), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .d_done(d_done), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_access_size(mem_access_size), .mem_rw(mem_rw), .mem_enable(mem_enable),
    .mem_busy(mem_busy), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  assign all_out = {if_grant, if_rvalid, if_done, d_wready, d_grant, d_rvalid, d_done,
                    mem_enable, mem_rw, mem_access_size, mem_address, mem_data_in,
                    if_rdata, d_rdata};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 0; d_req = 0; d_rw = 0; mem_busy = 0;
    if_addr = 0; d_addr = 0; if_size = 0; d_size = 0; d_wdata = 32'h5A5A5A5A;
    mem_data_out = 32'h12345678;
    step(); step(); #1;
    vec_cnt++;
    if (all_out !== '0) begin
      err_cnt++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    reset = 1'b0;
    step(); #1;
    vec_cnt++;
    if (all_out !== '0) begin
      err_cnt++; $display("FAIL idle_outputs: got %h want 0", all_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_fetch();
    if_req = 1; if_addr = 32'h80020000; if_size = 2'b00; #1;
    vec_cnt++;
    if ({if_grant, d_grant, mem_enable} !== 3'b100) begin
      err_cnt++; $display("FAIL t1_grant: got %b want 100", {if_grant, d_grant, mem_enable});
    end
    step(); if_req = 0; mem_data_out = 32'hCAFE0001; #1;
    vec_cnt++;
    if ({mem_enable, mem_rw, mem_access_size, mem_address, if_rvalid} !== {1'b1, 1'b1, 2'b00, 32'h80020000, 1'b0}) begin
      err_cnt++; $display("FAIL t1_beat: en=%b rw=%b sz=%b addr=%h rv=%b want 1 1 00 80020000 0",
                          mem_enable, mem_rw, mem_access_size, mem_address, if_rvalid);
    end
    step(); #1;
    vec_cnt++;
    if ({if_rvalid, if_done, if_rdata, mem_enable, d_rvalid} !== {1'b1, 1'b1, 32'hCAFE0001, 1'b0, 1'b0}) begin
      err_cnt++; $display("FAIL t1_drain: rv=%b done=%b rdata=%h en=%b drv=%b want 1 1 cafe0001 0 0",
                          if_rvalid, if_done, if_rdata, mem_enable, d_rvalid);
    end
    step(); #1;
    vec_cnt++;
    if (all_out !== '0) begin
      err_cnt++; $display("FAIL t1_idle: got %h want 0", all_out);
    end
    $display("test_single_fetch done");
  endtask

  task automatic test_write_burst();
    d_req = 1; d_rw = 0; d_addr = 32'h80020013; d_size = 2'b01; #1;
    vec_cnt++;
    if ({d_grant, if_grant} !== 2'b10) begin
      err_cnt++; $display("FAIL t2_grant: got %b want 10", {d_grant, if_grant});
    end
    step(); d_req = 0;
    for (int i = 0; i < 4; i++) begin
      d_wdata = 32'h11110000 + i; #1;
      vec_cnt++;
      if ({mem_address, mem_rw, mem_enable, mem_access_size, d_wready, mem_data_in, d_rvalid} !==
          {32'h80020010 + 32'(4 * i), 1'b0, 1'b1, 2'b01, 1'b1, 32'h11110000 + 32'(i), 1'b0}) begin
        err_cnt++; $display("FAIL t2_beat%0d: addr=%h rw=%b en=%b sz=%b wr=%b din=%h want addr=%h rw=0 en=1 sz=01 wr=1 din=%h",
                            i, mem_address, mem_rw, mem_enable, mem_access_size, d_wready, mem_data_in,
                            32'h80020010 + 32'(4 * i), 32'h11110000 + 32'(i));
      end
      step();
    end
    #1;
    vec_cnt++;
    if ({d_done, d_wready, mem_enable, d_rvalid} !== 4'b1000) begin
      err_cnt++; $display("FAIL t2_done: got %b want 1000", {d_done, d_wready, mem_enable, d_rvalid});
    end
    step(); #1;
    vec_cnt++;
    if (d_done !== 1'b0) begin
      err_cnt++; $display("FAIL t2_done_pulse: got %b want 0", d_done);
    end
    $display("test_write_burst done");
  endtask

  task automatic test_fairness();
    if_req = 1; d_req = 1; d_rw = 1; if_addr = 32'h80020000; d_addr = 32'h80020040;
    if_size = 2'b00; d_size = 2'b00; #1;
    vec_cnt++;
    if ({if_grant, d_grant} !== 2'b10) begin
      err_cnt++; $display("FAIL t3_tie1: got %b want 10", {if_grant, d_grant});
    end
    step(); if_req = 0; #1;
    vec_cnt++;
    if (d_grant !== 1'b0) begin
      err_cnt++; $display("FAIL t3_wait_burst: got %b want 0", d_grant);
    end
    step(); #1;
    vec_cnt++;
    if ({if_done, d_grant} !== 2'b10) begin
      err_cnt++; $display("FAIL t3_fetch_done: got %b want 10", {if_done, d_grant});
    end
    step(); #1;
    vec_cnt++;
    if ({d_grant, if_grant} !== 2'b10) begin
      err_cnt++; $display("FAIL t3_d_grant: got %b want 10", {d_grant, if_grant});
    end
    step(); d_req = 0; #1;
    vec_cnt++;
    if ({mem_address, mem_rw} !== {32'h80020040, 1'b1}) begin
      err_cnt++; $display("FAIL t3_d_beat: addr=%h rw=%b want 80020040 1", mem_address, mem_rw);
    end
    step(); #1;
    vec_cnt++;
    if ({d_done, d_rvalid, if_rvalid} !== 3'b110) begin
      err_cnt++; $display("FAIL t3_d_done: got %b want 110", {d_done, d_rvalid, if_rvalid});
    end
    step(); if_req = 1; d_req = 1; #1;
    vec_cnt++;
    if ({if_grant, d_grant} !== 2'b10) begin
      err_cnt++; $display("FAIL t3_tie2: got %b want 10", {if_grant, d_grant});
    end
    step(); if_req = 0; step(); step(); #1;
    vec_cnt++;
    if ({if_grant, d_grant} !== 2'b01) begin
      err_cnt++; $display("FAIL t3_tie3: got %b want 01", {if_grant, d_grant});
    end
    step(); d_req = 0; step(); step();
    $display("test_fairness done");
  endtask

  task automatic test_busy_stall();
    int beat = 0;
    int rv_cnt = 0;
    logic prev_acc = 1'b0;
    if_req = 1; if_addr = 32'h80020000; if_size = 2'b10; #1;
    vec_cnt++;
    if (if_grant !== 1'b1) begin
      err_cnt++; $display("FAIL t4_grant: got %b want 1", if_grant);
    end
    step(); if_req = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      mem_busy = (cyc == 2 || cyc == 3);
      mem_data_out = 32'hB0000000 + 32'(cyc); #1;
      vec_cnt++;
      if ({mem_address, if_rvalid, if_done} !== {32'h80020000 + 32'(4 * beat), prev_acc, 1'b0}) begin
        err_cnt++; $display("FAIL t4_cyc%0d: addr=%h rv=%b done=%b want %h %b 0",
                            cyc, mem_address, if_rvalid, if_done, 32'h80020000 + 32'(4 * beat), prev_acc);
      end
      if (prev_acc) begin
        vec_cnt++;
        if (if_rdata !== mem_data_out) begin
          err_cnt++; $display("FAIL t4_rdata%0d: got %h want %h", cyc, if_rdata, mem_data_out);
        end
      end
      if (if_rvalid === 1'b1) rv_cnt++;
      prev_acc = !mem_busy;
      if (!mem_busy) beat++;
      step();
    end
    mem_busy = 0; mem_data_out = 32'hB00000FF; #1;
    vec_cnt++;
    if ({if_done, if_rvalid, if_rdata, mem_enable} !== {1'b1, 1'b1, 32'hB00000FF, 1'b0}) begin
      err_cnt++; $display("FAIL t4_drain: done=%b rv=%b rdata=%h en=%b want 1 1 b00000ff 0",
                          if_done, if_rvalid, if_rdata, mem_enable);
    end
    if (if_rvalid === 1'b1) rv_cnt++;
    step(); #1;
    vec_cnt++;
    if ({rv_cnt, if_done, if_rvalid} !== {32'd8, 1'b0, 1'b0}) begin
      err_cnt++; $display("FAIL t4_count: rvalids=%0d done=%b rv=%b want 8 0 0", rv_cnt, if_done, if_rvalid);
    end
    $display("test_busy_stall done");
  endtask

  task automatic test_reset_abort();
    d_req = 1; d_rw = 1; d_addr = 32'h80020100; d_size = 2'b11; #1;
    vec_cnt++;
    if (d_grant !== 1'b1) begin
      err_cnt++; $display("FAIL t5_grant: got %b want 1", d_grant);
    end
    step(); d_req = 0;
    step(); step(); step();
    reset = 1; #1;
    vec_cnt++;
    if (mem_address !== 32'h8002010C) begin
      err_cnt++; $display("FAIL t5_beat3: got %h want 8002010c", mem_address);
    end
    step(); #1;
    vec_cnt++;
    if (all_out !== '0) begin
      err_cnt++; $display("FAIL t5_abort: got %h want 0", all_out);
    end
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      vec_cnt++;
      if (all_out !== '0) begin
        err_cnt++; $display("FAIL t5_post%0d: got %h want 0", i, all_out);
      end
    end
    if_req = 1; if_addr = 32'h80020200; if_size = 2'b00; #1;
    vec_cnt++;
    if (if_grant !== 1'b1) begin
      err_cnt++; $display("FAIL t5_fresh_grant: got %b want 1", if_grant);
    end
    step(); if_req = 0; #1;
    vec_cnt++;
    if ({mem_enable, mem_address} !== {1'b1, 32'h80020200}) begin
      err_cnt++; $display("FAIL t5_fresh_beat: en=%b addr=%h want 1 80020200", mem_enable, mem_address);
    end
    step(); #1;
    vec_cnt++;
    if ({if_done, if_rvalid, d_done} !== 3'b110) begin
      err_cnt++; $display("FAIL t5_fresh_done: got %b want 110", {if_done, if_rvalid, d_done});
    end
    step();
    $display("test_reset_abort done");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'hFFFFFFF8; exp_addr[1] = 32'hFFFFFFFC;
    exp_addr[2] = 32'h00000000; exp_addr[3] = 32'h00000004;
    if_req = 1; if_addr = 32'hFFFFFFF8; if_size = 2'b01; #1;
    step(); if_req = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vec_cnt++;
      if (mem_address !== exp_addr[i]) begin
        err_cnt++; $display("FAIL t6_addr%0d: got %h want %h", i, mem_address, exp_addr[i]);
      end
      step();
    end
    #1;
    vec_cnt++;
    if ({if_done, mem_enable} !== 2'b10) begin
      err_cnt++; $display("FAIL t6_done: got %b want 10", {if_done, mem_enable});
    end
    step();
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_write_burst();
    test_fairness();
    test_busy_stall();
    test_reset_abort();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
